// File: rtl/fpu_pkg.sv
// Shared floating-point types and constants for the FPU datapath.
// fp_t and the QNAN/INF constants describe the default single-precision
// layout; parametrised blocks slice their own vectors to the same field order
// {sign, exp, man}.
package fpu_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_BIAS  = (1 << (FP_EXP_W - 1)) - 1;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W-1:0] man;
    } fp_t;

    localparam fp_t FP_QNAN    = '{sign: 1'b0, exp: '1, man: {1'b1, {(FP_MAN_W-1){1'b0}}}};
    localparam fp_t FP_INF_POS = '{sign: 1'b0, exp: '1, man: '0};
    localparam fp_t FP_INF_NEG = '{sign: 1'b1, exp: '1, man: '0};

    // Operand classification; subnormals are reported as FP_ZERO (flushed).
    typedef enum logic [1:0] {
        FP_NORM = 2'd0,
        FP_ZERO = 2'd1,
        FP_INF  = 2'd2,
        FP_NAN  = 2'd3
    } fp_class_e;

    // Bit positions inside the 3-bit flag vector {invalid, overflow, inexact}.
    localparam int FLAG_INVALID  = 2;
    localparam int FLAG_OVERFLOW = 1;
    localparam int FLAG_INEXACT  = 0;

endpackage

// File: rtl/fadd_norm_round.sv
// Combinational normalise + round stage of the floating-point adder.
// Takes the raw aligned sum (carry, hidden, MAN_W, guard, round, sticky),
// normalises it, rounds to nearest-even, clamps overflow to infinity and
// flushes underflow to signed zero. Special tags bypass the datapath.
// Ports:
//   sum      in  MAN_W+5  raw magnitude sum from the add stage
//   exp      in  EXP_W    exponent of the larger operand
//   sign     in  1        result sign (or infinity sign for FP_INF tag)
//   eff_sub  in  1        effective subtraction (exact zero becomes +0)
//   tag      in  2        special-case class carried from the unpack stage
//   result   out W        packed rounded result
//   overflow out 1        finite result rounded to infinity (FADD_FLAGS_EN)
//   inexact  out 1        precision lost (FADD_FLAGS_EN)
module fadd_norm_round
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [MAN_W+4:0]     sum,
    input  logic [EXP_W-1:0]     exp,
    input  logic                 sign,
    input  logic                 eff_sub,
    input  fp_class_e            tag,
    output logic [EXP_W+MAN_W:0] result
`ifdef FADD_FLAGS_EN
    ,
    output logic                 overflow,
    output logic                 inexact
`endif
);

    localparam int AW  = MAN_W + 4;
    localparam int LZW = $clog2(AW + 1);
    localparam int EW  = EXP_W + 2;

    localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] E_ONE  = EW'(1);
    localparam logic signed [EW-1:0] E_ZERO = EW'(0);

    logic [LZW-1:0]       lzc;
    logic [AW-1:0]        mant;
    logic signed [EW-1:0] e_n;
    logic signed [EW-1:0] e_r;
    logic                 g, r, s;
    logic                 round_up;
    logic                 is_zero;
    logic [MAN_W:0]       frac_r;

    always_comb begin
        // Last set bit wins, so the scan leaves the count for the highest one.
        lzc = '0;
        for (int i = 0; i < AW; i++) begin
            if (sum[i]) lzc = LZW'(AW - 1 - i);
        end

        if (sum[AW]) begin
            mant = {sum[AW:2], sum[1] | sum[0]};
            e_n  = $signed({2'b00, exp}) + E_ONE;
        end else begin
            mant = sum[AW-1:0] << lzc;
            e_n  = $signed({2'b00, exp}) - $signed({{(EW-LZW){1'b0}}, lzc});
        end

        g        = mant[2];
        r        = mant[1];
        s        = mant[0];
        round_up = g & (r | s | mant[3]);

        // Fraction-only increment; a carry out means the significand reached 2.0.
        frac_r = {1'b0, mant[AW-2:3]} + {{MAN_W{1'b0}}, round_up};
        e_r    = e_n + $signed({{(EW-1){1'b0}}, frac_r[MAN_W]});

        // After normalisation the hidden bit is clear only for an all-zero sum.
        is_zero = !mant[AW-1];

        result = '0;
        if (tag == FP_NAN) begin
            result = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        end else if (tag == FP_INF) begin
            result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (is_zero) begin
            result = {sign & !eff_sub, {(EXP_W+MAN_W){1'b0}}};
        end else if (e_r >= E_MAX) begin
            result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (e_r <= E_ZERO) begin
            result = {sign, {(EXP_W+MAN_W){1'b0}}};
        end else begin
            result = {sign, e_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
        end
    end

`ifdef FADD_FLAGS_EN
    always_comb begin
        overflow = (tag == FP_NORM) && !is_zero && (e_r >= E_MAX);
        inexact  = (tag == FP_NORM) && (g | r | s | overflow);
    end
`endif

endmodule

// File: rtl/fadd_pipe.sv
// Three-stage pipelined IEEE-754 adder/subtractor (align / add / norm+round).
// Whole-pipe stall: every stage advances only when the output register is
// empty or being drained. Subnormal inputs and outputs are flushed to zero.
// Optional feature macro: FADD_FLAGS_EN adds flags_o {invalid, overflow,
// inexact}, pipelined alongside the data.
// Ports:
//   clk_i        in  1  clock
//   rst_i        in  1  synchronous active-high reset
//   in_valid_i   in  1  operand pair valid
//   in_ready_o   out 1  operands accepted this cycle
//   operand_a_i  in  W  operand A
//   operand_b_i  in  W  operand B
//   sub_i        in  1  1: A-B, 0: A+B
//   out_valid_o  out 1  result_o valid
//   out_ready_i  in  1  downstream accepts result
//   result_o     out W  rounded sum
//   flags_o      out 3  {invalid, overflow, inexact} (FADD_FLAGS_EN only)
module fadd_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [EXP_W+MAN_W:0] operand_a_i,
    input  logic [EXP_W+MAN_W:0] operand_b_i,
    input  logic                 sub_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [EXP_W+MAN_W:0] result_o
`ifdef FADD_FLAGS_EN
    ,
    output logic [2:0]           flags_o
`endif
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int AW = MAN_W + 4;
    localparam int SW = MAN_W + 5;

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        if (e == '1)      return (m != '0) ? FP_NAN : FP_INF;
        else if (e == '0) return FP_ZERO;
        else              return FP_NORM;
    endfunction

    logic adv;

    // ---------------- S1: unpack, classify, swap, align ----------------
    logic                   a_sign, b_sign;
    logic [EXP_W-1:0]       a_exp, b_exp;
    logic [MAN_W-1:0]       a_man, b_man;
    fp_class_e              a_cls, b_cls;
    logic [EXP_W+MAN_W-1:0] a_mag, b_mag;
    logic                   swap;
    logic [EXP_W-1:0]       l_exp, s_exp, d;
    logic [MAN_W:0]         l_sig, s_sig;
    logic [2*AW-1:0]        wide;
    logic [AW-1:0]          s_al;
    logic                   inf_inf;
    fp_class_e              tag_d;
    logic                   sign_d;
    logic                   eff_d;

    always_comb begin
        a_sign = operand_a_i[W-1];
        a_exp  = operand_a_i[W-2:MAN_W];
        a_man  = operand_a_i[MAN_W-1:0];
        b_sign = operand_b_i[W-1] ^ sub_i;
        b_exp  = operand_b_i[W-2:MAN_W];
        b_man  = operand_b_i[MAN_W-1:0];

        a_cls = classify(a_exp, a_man);
        b_cls = classify(b_exp, b_man);

        // Subnormal fractions are dropped so they behave as signed zeros.
        a_mag = {a_exp, (a_exp == '0) ? {MAN_W{1'b0}} : a_man};
        b_mag = {b_exp, (b_exp == '0) ? {MAN_W{1'b0}} : b_man};
        swap  = b_mag > a_mag;

        l_exp = swap ? b_exp : a_exp;
        s_exp = swap ? a_exp : b_exp;
        l_sig = swap ? {|b_exp, b_mag[MAN_W-1:0]} : {|a_exp, a_mag[MAN_W-1:0]};
        s_sig = swap ? {|a_exp, a_mag[MAN_W-1:0]} : {|b_exp, b_mag[MAN_W-1:0]};
        d     = l_exp - s_exp;

        // Low half of the wide shift collects everything that falls off as sticky.
        wide = {s_sig, 3'b000, {AW{1'b0}}} >> d;
        if (int'(d) >= MAN_W + 3) s_al = {{(AW-1){1'b0}}, |s_sig};
        else                      s_al = wide[2*AW-1:AW] | {{(AW-1){1'b0}}, |wide[AW-1:0]};

        eff_d   = a_sign ^ b_sign;
        inf_inf = (a_cls == FP_INF) && (b_cls == FP_INF) && eff_d;

        tag_d  = FP_NORM;
        sign_d = swap ? b_sign : a_sign;
        if (a_cls == FP_NAN || b_cls == FP_NAN || inf_inf) begin
            tag_d  = FP_NAN;
            sign_d = 1'b0;
        end else if (a_cls == FP_INF) begin
            tag_d  = FP_INF;
            sign_d = a_sign;
        end else if (b_cls == FP_INF) begin
            tag_d  = FP_INF;
            sign_d = b_sign;
        end
    end

`ifdef FADD_FLAGS_EN
    logic invalid_d;
    assign invalid_d = inf_inf
                     | (a_cls == FP_NAN && !a_man[MAN_W-1])
                     | (b_cls == FP_NAN && !b_man[MAN_W-1]);
    logic s1_invalid, s2_invalid;
`endif

    logic             s1_valid;
    fp_class_e        s1_tag;
    logic             s1_sign;
    logic             s1_eff_sub;
    logic [EXP_W-1:0] s1_exp;
    logic [MAN_W:0]   s1_lsig;
    logic [AW-1:0]    s1_ssig;

    // ---------------- S2: effective add/subtract ----------------
    logic [SW-1:0]    sum_d;

    always_comb begin
        if (s1_eff_sub) sum_d = {1'b0, s1_lsig, 3'b000} - {1'b0, s1_ssig};
        else            sum_d = {1'b0, s1_lsig, 3'b000} + {1'b0, s1_ssig};
    end

    logic             s2_valid;
    fp_class_e        s2_tag;
    logic             s2_sign;
    logic             s2_eff_sub;
    logic [EXP_W-1:0] s2_exp;
    logic [SW-1:0]    s2_sum;

    // ---------------- S3: normalise + round ----------------
    logic [W-1:0]     nr_result;
`ifdef FADD_FLAGS_EN
    logic             nr_overflow, nr_inexact;
`endif

    fadd_norm_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_norm_round (
        .sum      (s2_sum),
        .exp      (s2_exp),
        .sign     (s2_sign),
        .eff_sub  (s2_eff_sub),
        .tag      (s2_tag),
        .result   (nr_result)
`ifdef FADD_FLAGS_EN
        ,
        .overflow (nr_overflow),
        .inexact  (nr_inexact)
`endif
    );

    assign in_ready_o = !out_valid_o | out_ready_i;
    assign adv        = in_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid    <= 1'b0;
            s1_tag      <= FP_NORM;
            s1_sign     <= 1'b0;
            s1_eff_sub  <= 1'b0;
            s1_exp      <= '0;
            s1_lsig     <= '0;
            s1_ssig     <= '0;
            s2_valid    <= 1'b0;
            s2_tag      <= FP_NORM;
            s2_sign     <= 1'b0;
            s2_eff_sub  <= 1'b0;
            s2_exp      <= '0;
            s2_sum      <= '0;
            out_valid_o <= 1'b0;
            result_o    <= '0;
`ifdef FADD_FLAGS_EN
            s1_invalid  <= 1'b0;
            s2_invalid  <= 1'b0;
            flags_o     <= '0;
`endif
        end else if (adv) begin
            s1_valid    <= in_valid_i;
            s1_tag      <= tag_d;
            s1_sign     <= sign_d;
            s1_eff_sub  <= eff_d;
            s1_exp      <= l_exp;
            s1_lsig     <= l_sig;
            s1_ssig     <= s_al;
            s2_valid    <= s1_valid;
            s2_tag      <= s1_tag;
            s2_sign     <= s1_sign;
            s2_eff_sub  <= s1_eff_sub;
            s2_exp      <= s1_exp;
            s2_sum      <= sum_d;
            out_valid_o <= s2_valid;
            if (s2_valid) result_o <= nr_result;
`ifdef FADD_FLAGS_EN
            s1_invalid  <= invalid_d;
            s2_invalid  <= s1_invalid;
            if (s2_valid) begin
                flags_o[FLAG_INVALID]  <= s2_invalid;
                flags_o[FLAG_OVERFLOW] <= nr_overflow;
                flags_o[FLAG_INEXACT]  <= nr_inexact;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fadd_pipe.sv
module tb_fadd_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
`ifdef FADD_FLAGS_EN
    logic [2:0]  flags;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fadd_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .operand_a_i (operand_a),
        .operand_b_i (operand_b),
        .sub_i       (sub),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result)
`ifdef FADD_FLAGS_EN
        ,
        .flags_o     (flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // Drives one operation, waits (bounded) for its result; lat counts rising
    // edges from the accepting edge, inclusive.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [31:0] res, output logic [2:0] flg, output int lat);
        @(negedge clk);
        operand_a = a;
        operand_b = b;
        sub       = s;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        res = result;
`ifdef FADD_FLAGS_EN
        flg = flags;
`else
        flg = 3'b000;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0;
        operand_a = '0; operand_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 00000000", result); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
`ifdef FADD_FLAGS_EN
        n_checks++;
        if (flags !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", flags); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_basic_add();
        logic [31:0] res; logic [2:0] flg; int lat;
        run_op(32'h3F800000, 32'h3F800000, 1'b0, res, flg, lat);
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL add_latency: got %0d expected 3", lat); end
        n_checks++;
        if (res !== 32'h40000000) begin n_fail++; $display("FAIL add_1p1: got %h expected 40000000", res); end
`ifdef FADD_FLAGS_EN
        n_checks++;
        if (flg !== 3'b000) begin n_fail++; $display("FAIL add_1p1_flags: got %b expected 000", flg); end
`endif
        run_op(32'h00000001, 32'h3F800000, 1'b0, res, flg, lat);
        n_checks++;
        if (res !== 32'h3F800000) begin n_fail++; $display("FAIL add_subnormal_flush: got %h expected 3F800000", res); end
    endtask

    task automatic test_cancel();
        logic [31:0] res; logic [2:0] flg; int lat;
        run_op(32'h3F800000, 32'h3F800000, 1'b1, res, flg, lat);
        n_checks++;
        if (res !== 32'h00000000) begin n_fail++; $display("FAIL cancel_1m1: got %h expected 00000000", res); end
        run_op(32'h80000000, 32'h80000000, 1'b0, res, flg, lat);
        n_checks++;
        if (res !== 32'h80000000) begin n_fail++; $display("FAIL neg0_plus_neg0: got %h expected 80000000", res); end
        run_op(32'h00000000, 32'h80000000, 1'b0, res, flg, lat);
        n_checks++;
        if (res !== 32'h00000000) begin n_fail++; $display("FAIL pos0_plus_neg0: got %h expected 00000000", res); end
        run_op(32'hC0400000, 32'h40400000, 1'b0, res, flg, lat);
        n_checks++;
        if (res !== 32'h00000000) begin n_fail++; $display("FAIL cancel_m3p3: got %h expected 00000000", res); end
    endtask

    task automatic test_specials();
        logic [31:0] res; logic [2:0] flg; int lat;
        run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, res, flg, lat);
        n_checks++;
        if (res !== 32'h7F800000) begin n_fail++; $display("FAIL overflow_result: got %h expected 7F800000", res); end
`ifdef FADD_FLAGS_EN
        n_checks++;
        if (flg !== 3'b011) begin n_fail++; $display("FAIL overflow_flags: got %b expected 011", flg); end
`endif
        run_op(32'h7F800000, 32'hFF800000, 1'b0, res, flg, lat);
        n_checks++;
        if (res !== 32'h7FC00000) begin n_fail++; $display("FAIL inf_minus_inf: got %h expected 7FC00000", res); end
`ifdef FADD_FLAGS_EN
        n_checks++;
        if (flg !== 3'b100) begin n_fail++; $display("FAIL inf_minus_inf_flags: got %b expected 100", flg); end
`endif
        run_op(32'h3F800000, 32'hFF800000, 1'b0, res, flg, lat);
        n_checks++;
        if (res !== 32'hFF800000) begin n_fail++; $display("FAIL finite_plus_ninf: got %h expected FF800000", res); end
        run_op(32'h7FC00001, 32'h3F800000, 1'b0, res, flg, lat);
        n_checks++;
        if (res !== 32'h7FC00000) begin n_fail++; $display("FAIL qnan_in: got %h expected 7FC00000", res); end
    endtask

    task automatic test_rounding();
        logic [31:0] res; logic [2:0] flg; int lat;
        run_op(32'h3F800000, 32'h33800000, 1'b0, res, flg, lat);
        n_checks++;
        if (res !== 32'h3F800000) begin n_fail++; $display("FAIL rne_tie_even: got %h expected 3F800000", res); end
`ifdef FADD_FLAGS_EN
        n_checks++;
        if (flg !== 3'b001) begin n_fail++; $display("FAIL rne_tie_flags: got %b expected 001", flg); end
`endif
        run_op(32'h3F800001, 32'h33800000, 1'b0, res, flg, lat);
        n_checks++;
        if (res !== 32'h3F800002) begin n_fail++; $display("FAIL rne_tie_odd: got %h expected 3F800002", res); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic        vs [4];
        logic [31:0] vexp [4];
        logic [31:0] got [8];
        int n_got = 0;
        int issued = 0;
        int stall = 0;
        int bad_ready = 0;
        va[0] = 32'h3F800000; vb[0] = 32'h3F800000; vs[0] = 1'b0; vexp[0] = 32'h40000000;
        va[1] = 32'h3F800000; vb[1] = 32'h40000000; vs[1] = 1'b0; vexp[1] = 32'h40400000;
        va[2] = 32'h40000000; vb[2] = 32'h3F800000; vs[2] = 1'b1; vexp[2] = 32'h3F800000;
        va[3] = 32'h40400000; vb[3] = 32'h3F800000; vs[3] = 1'b0; vexp[3] = 32'h40800000;
        for (int i = 0; i < 8; i++) got[i] = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 6);
            in_valid  = (issued < 4);
            if (issued < 4) begin
                operand_a = va[issued];
                operand_b = vb[issued];
                sub       = vs[issued];
            end
            #1;
            if (out_valid && !out_ready) begin
                stall++;
                if (in_ready) bad_ready++;
            end
            if (out_valid && out_ready) begin
                if (n_got < 8) got[n_got] = result;
                n_got++;
            end
            if (in_valid && in_ready) issued++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (stall !== 3) begin n_fail++; $display("FAIL b2b_stall_cycles: got %0d expected 3", stall); end
        n_checks++;
        if (bad_ready !== 0) begin n_fail++; $display("FAIL b2b_in_ready_stalled: got %0d high cycles expected 0", bad_ready); end
        n_checks++;
        if (n_got !== 4) begin n_fail++; $display("FAIL b2b_result_count: got %0d expected 4", n_got); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got[i] !== vexp[i]) begin
                n_fail++;
                $display("FAIL b2b_result_%0d: got %h expected %h", i, got[i], vexp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            operand_a = 32'h3F800000;
            operand_b = 32'h3F800000;
            sub       = 1'b0;
            in_valid  = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (result !== 32'h0) begin n_fail++; $display("FAIL reset_mid_result: got %h expected 00000000", result); end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        n_checks++;
        if (stale !== 0) begin n_fail++; $display("FAIL reset_mid_stale: got %0d valid cycles expected 0", stale); end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_cancel();
        test_specials();
        test_rounding();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
